// File: rtl/enc16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | enc16_pkg                                                            |
// | Shared types and constants for the 16-to-4 capture encoder.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package enc16_pkg;

    localparam int N_LINES = 16;
    localparam int CODE_W  = 4;

    typedef enum logic {ST_IDLE, ST_HOLD} enc_state_t;
    typedef logic [CODE_W-1:0] code_t;

    function automatic logic [N_LINES-1:0] onehot16(input code_t c);
        return (N_LINES)'(1) << c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/encoder_16to4_capture_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prio_sel16                                                           |
// | Combinational priority pick: first set request at/after base (wraps).|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module prio_sel16
    import enc16_pkg::*;
(
    input  logic [N_LINES-1:0] req,
    input  code_t              base,
    input  logic               rr_en,
    output code_t              idx,
    output logic               found
);

    code_t start;
    code_t cand;

    // Walk offsets from far to near so the nearest set line is the last write.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        start = rr_en ? base : '0;
        cand  = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            cand = start + code_t'(i);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/encoder_16to4_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | encoder_16to4_capture                                                |
// | Captures request events, encodes one pending line per handshake.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module encoder_16to4_capture
    import enc16_pkg::*;
#(
    parameter bit EDGE_MODE = 1'b1,
    parameter bit RR_EN     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N_LINES-1:0] Y,
    input  logic               ready,
    output logic               A,
    output logic               B,
    output logic               C,
    output logic               D,
    output logic               valid,
    output logic               any,
    output logic               dropped
);

    enc_state_t         state_q, state_d;
    code_t              code_q, code_d;
    code_t              rr_ptr_q, rr_ptr_d;
    logic               valid_q, valid_d;
    logic               any_q, dropped_q;
    logic [N_LINES-1:0] prev_y_q;
    logic [N_LINES-1:0] pending_q, pending_d;
    logic [N_LINES-1:0] ev, clr;
    logic               accept;
    logic               dropped_d;
    code_t              sel_idx;
    logic               sel_found;

    prio_sel16 u_prio (
        .req   (pending_q),
        .base  (rr_ptr_q),
        .rr_en (RR_EN),
        .idx   (sel_idx),
        .found (sel_found)
    );

    always_comb begin
        ev        = en ? (EDGE_MODE ? (Y & ~prev_y_q) : Y) : '0;
        clr       = accept ? onehot16(code_q) : '0;
        pending_d = (pending_q & ~clr) | ev;
        dropped_d = |(ev & pending_q & ~clr);
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (sel_found) begin
                    code_d  = sel_idx;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ready) begin
                    accept   = 1'b1;
                    valid_d  = 1'b0;
                    rr_ptr_d = code_q + code_t'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // prev_y keeps tracking Y through reset so a line held high across
    // reset release is not mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        prev_y_q <= Y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            rr_ptr_q  <= '0;
            valid_q   <= 1'b0;
            any_q     <= 1'b0;
            dropped_q <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            rr_ptr_q  <= rr_ptr_d;
            valid_q   <= valid_d;
            any_q     <= |pending_d;
            dropped_q <= dropped_d;
            pending_q <= pending_d;
        end
    end

    assign {A, B, C, D} = code_q;
    assign valid        = valid_q;
    assign any          = any_q;
    assign dropped      = dropped_q;

endmodule
`default_nettype wire
